// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register. After reset, a sequencer
// zeroes the data memory while holding busy high.
module mem_wb_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mdestReg,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  input  logic        stall,
  output logic        busy,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wdestReg,
  output logic [31:0] wr,
  output logic [31:0] wdo,
  output logic [31:0] wbData,
  output logic        memErr
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          r_state, w_next_state;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_mem [DEPTH];

  logic            w_valid;
  logic [AW-1:0]   w_widx;
  logic [31:0]     w_mdo;
  logic            w_store;
  logic            w_run;

  assign w_widx  = mr[AW+1:2];
  assign w_valid = (mr[1:0] == 2'b00) && (mr[31:AW+2] == '0);
  assign w_run   = (r_state == RUN);
  assign w_store = w_run && mwmem && w_valid && !stall;
  assign w_mdo   = (w_run && w_valid) ? r_mem[w_widx] : '0;
  assign busy    = (r_state == CLEAR);

  always_comb begin
    w_next_state = r_state;
    if ((r_state == CLEAR) && (r_idx == LAST_IDX))
      w_next_state = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == CLEAR)
        r_idx <= r_idx + 1'b1;
    end
  end

  // The clear sequencer and the store port share the single write port;
  // they never overlap because stores are only accepted in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR)
        r_mem[r_idx] <= '0;
      else if (w_store)
        r_mem[w_widx] <= mqb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      memErr <= 1'b0;
    else if (w_run && !stall && (mwmem || mm2reg) && !w_valid)
      memErr <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == CLEAR)) begin
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wdestReg <= '0;
      wr       <= '0;
      wdo      <= '0;
    end else if (!stall) begin
      wwreg    <= mwreg;
      wm2reg   <= mm2reg;
      wdestReg <= mdestReg;
      wr       <= mr;
      wdo      <= w_mdo;
    end
  end

  assign wbData = wm2reg ? wdo : wr;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0, stall = 1'b0;
  logic [4:0]  mdestReg = '0;
  logic [31:0] mr = '0, mqb = '0;
  logic        busy, wwreg, wm2reg, memErr;
  logic [4:0]  wdestReg;
  logic [31:0] wr, wdo, wbData;

  mem_wb_stage #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst(rst), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mdestReg(mdestReg), .mr(mr), .mqb(mqb), .stall(stall), .busy(busy),
    .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg), .wr(wr), .wdo(wdo),
    .wbData(wbData), .memErr(memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        busy, wwreg, wm2reg, err;
    logic [4:0]  dest;
    logic [31:0] wr, wdo, wb;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        mon_bad;
  exp_t        mon_e;

  logic        h_wwreg = 1'b0, h_wm2reg = 1'b0;
  logic [4:0]  h_dest = '0;
  logic [31:0] h_wr = '0, h_wdo = '0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      mon_bad = 1'b0;
      if (busy !== mon_e.busy)       mon_bad = 1'b1;
      if (wwreg !== mon_e.wwreg)     mon_bad = 1'b1;
      if (wm2reg !== mon_e.wm2reg)   mon_bad = 1'b1;
      if (wdestReg !== mon_e.dest)   mon_bad = 1'b1;
      if (wr !== mon_e.wr)           mon_bad = 1'b1;
      if (wdo !== mon_e.wdo)         mon_bad = 1'b1;
      if (wbData !== mon_e.wb)       mon_bad = 1'b1;
      if (memErr !== mon_e.err)      mon_bad = 1'b1;
      if (mon_bad) begin
        n_bad++;
        $display("FAIL %s: got busy=%b wwreg=%b wm2reg=%b dest=%0d wr=%h wdo=%h wb=%h err=%b ; want busy=%b wwreg=%b wm2reg=%b dest=%0d wr=%h wdo=%h wb=%h err=%b",
                 mon_e.name, busy, wwreg, wm2reg, wdestReg, wr, wdo, wbData, memErr,
                 mon_e.busy, mon_e.wwreg, mon_e.wm2reg, mon_e.dest, mon_e.wr,
                 mon_e.wdo, mon_e.wb, mon_e.err);
      end
    end
  end

  task automatic step(input logic r, input logic wreg, input logic m2reg,
                      input logic wmem, input logic [4:0] dest,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic stl, input logic bub, input logic [31:0] e_wdo,
                      input logic e_err, input logic e_busy, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; mwreg = wreg; mm2reg = m2reg; mwmem = wmem; mdestReg = dest;
    mr = addr; mqb = data; stall = stl;
    @(posedge clk);
    #1;
    if (bub) begin
      h_wwreg = 1'b0; h_wm2reg = 1'b0; h_dest = '0; h_wr = '0; h_wdo = '0;
    end else if (!stl) begin
      h_wwreg = wreg; h_wm2reg = m2reg; h_dest = dest; h_wr = addr; h_wdo = e_wdo;
    end
    e.name = nm; e.busy = e_busy; e.err = e_err;
    e.wwreg = h_wwreg; e.wm2reg = h_wm2reg; e.dest = h_dest;
    e.wr = h_wr; e.wdo = h_wdo; e.wb = h_wm2reg ? h_wdo : h_wr;
    exp_q.push_back(e);
  endtask

  task automatic ld(input logic [31:0] addr, input logic [4:0] dest,
                    input logic [31:0] e_wdo, input logic e_err, input string nm);
    step(0, 1, 1, 0, dest, addr, 32'h0BAD_F00D, 0, 0, e_wdo, e_err, 0, nm);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data,
                    input logic [31:0] e_wdo, input logic e_err, input string nm);
    step(0, 0, 0, 1, 5'd0, addr, data, 0, 0, e_wdo, e_err, 0, nm);
  endtask

  task automatic clear_run(input string tag);
    for (int unsigned i = 1; i <= 64; i++)
      step(0, 1, 1, (i == 5), 5'd9, 32'h0000_000C, 32'h0000_0077, i[0], 1,
           32'h0, 0, (i < 64), $sformatf("%s_%0d", tag, i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1, "reset");
    clear_run("clear");

    ld(32'h0000_0010, 5'd3, 32'h0, 0, "load_after_clear");
    st(32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 0, "store_8");
    ld(32'h0000_0008, 5'd5, 32'hDEAD_BEEF, 0, "load_8");
    step(0, 1, 0, 0, 5'd7, 32'h0000_1234, 32'h0, 0, 0, 32'h0, 0, 0, "alu_wb");
    ld(32'h0000_0008, 5'd5, 32'hDEAD_BEEF, 0, "load_8_again");

    st(32'h0000_0004, 32'hA5A5_A5A5, 32'h0, 0, "store_4");
    st(32'h0000_0006, 32'h1234_5678, 32'h0, 1, "misaligned_store");
    ld(32'h0000_0004, 5'd2, 32'hA5A5_A5A5, 1, "idx1_unchanged");
    ld(32'h0000_0100, 5'd4, 32'h0, 1, "out_of_range_load");

    step(0, 1, 0, 1, 5'd31, 32'h0000_0004, 32'h0000_0055, 1, 0, 32'h0, 1, 0, "stall_store");
    step(0, 0, 1, 1, 5'd17, 32'h0000_0104, 32'hFFFF_FFFF, 1, 0, 32'h0, 1, 0, "stall_bad_addr");
    st(32'h0000_0004, 32'h0000_0055, 32'hA5A5_A5A5, 1, "store_after_stall");
    ld(32'h0000_0004, 5'd6, 32'h0000_0055, 1, "load_after_stall");

    step(1, 1, 1, 1, 5'd1, 32'h0000_0008, 32'h1, 0, 1, 32'h0, 0, 1, "reset2");
    for (int unsigned i = 1; i <= 30; i++)
      step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0, 0, 1, $sformatf("preabort_%0d", i));
    step(1, 0, 0, 1, 5'd0, 32'h0000_0008, 32'h2, 0, 1, 32'h0, 0, 1, "reset_mid_clear");
    clear_run("reclear");

    for (int unsigned i = 0; i < 64; i++)
      ld(32'(i * 4), 5'(i), 32'h0, 0, $sformatf("zero_word_%0d", i));

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad == 0)
      $display("PASS");
    else
      $display("FAIL %0d mismatches", n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the pipelined CPU. It consumes the EXE/MEM register outputs, performs word loads and stores against an internal data memory, and registers the results toward writeback. After reset it runs a self-clearing sequencer that zeroes the data memory and holds `busy` high so the upstream stages can stall until it finishes.

## Interface
Parameters:
- `DEPTH`, 64: data memory words; power of two, 4..1024.
- `AW`, 6: word-index width, equal to log2(DEPTH).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `mwreg`  in  1  instruction writes the register file.
- `mm2reg`  in  1  writeback selects memory data (load).
- `mwmem`  in  1  store enable.
- `mdestReg`  in  5  destination register.
- `mr`  in  32  ALU result; byte address for loads and stores.
- `mqb`  in  32  store data.
- `stall`  in  1  hold the MEM/WB register and suppress the store.
- `busy`  out  1  memory clear in progress; upstream must stall.
- `wwreg`  out  1  registered `mwreg`.
- `wm2reg`  out  1  registered `mm2reg`.
- `wdestReg`  out  5  registered `mdestReg`.
- `wr`  out  32  registered `mr`.
- `wdo`  out  32  registered memory read data.
- `wbData`  out  32  writeback value: `wm2reg ? wdo : wr` (combinational).
- `memErr`  out  1  sticky error flag for a misaligned or out-of-range access.

## Operation
- **Address decode**
  - Word index is `mr[AW+1:2]`.
  - The access is valid when `mr[1:0]==0` and `mr[31:AW+2]==0`.
- **State machine**, two states, CLEAR and RUN.
  - `rst` enters CLEAR with clear index 0.
  - In CLEAR, each cycle writes 0 to `mem[idx]` and increments `idx`.
  - When `idx==DEPTH-1` is written, the next state is RUN.
  - `busy` is 1 exactly while in CLEAR.
  - RUN holds until the next `rst`.
- **Read**
  - Combinational from the array: `mdo = valid ? mem[idx] : 0`.
  - `mdo` is forced to 0 in CLEAR.
- **Store**
  - `mem[idx] <= mqb` at the rising edge when RUN, `mwmem`, valid, and `!stall` all hold.
  - Invalid-address stores are dropped.
- **Error flag**
  - `memErr` is set to 1 at the edge when RUN, `!stall`, `(mwmem|mm2reg)`, and the address is invalid.
  - It clears only on `rst`.
- **MEM/WB register**
  - In RUN with `!stall`, it loads `mwreg`, `mm2reg`, `mdestReg`, `mr`, and `mdo`.
  - With `stall`=1 it holds every field.
  - In CLEAR it loads a bubble: all fields 0.
- **Reset values**
  - `wwreg`, `wm2reg`, `wdestReg`, `wr`, `wdo`, and `memErr` are 0.
  - `busy` is 1.
  - `wbData` is 0.
- **Simultaneous events**
  - `rst` dominates all other inputs.
  - `rst` asserted mid-clear restarts the clear at index 0.
  - `rst` asserted in RUN discards any pending store that cycle.
  - `stall` during CLEAR has no effect; clearing continues.

## Timing
- Clear takes DEPTH cycles.
  - `busy` is 1 from the reset edge through the edge that writes the last word.
  - `busy` falls after DEPTH rising edges following the `rst` deassertion edge.
- Load latency is 1 cycle: the address presented in cycle N appears on `wdo`/`wbData` after edge N.
- Store is visible to a combinational read in the cycle after its edge.
  - A load directly following a store to the same address returns the new data.
- No same-cycle store-to-load forwarding is needed, since each instruction does either a load or a store.
- `wbData` changes only after clock edges; there is no combinational path from stage inputs to `wbData`.

## Test plan
- **Reset/clear**
  - Stimulus: hold `rst` for 1 cycle, then release.
  - Required: `busy`=1 for 64 cycles, then 0; every output is 0 during the clear; a load at address 0x10 after the clear returns `wdo`=0.
- **Store then load**
  - Stimulus: store `mqb`=0xDEADBEEF at `mr`=0x0000_0008, then load 0x8 with `mm2reg`=1 and `mdestReg`=5.
  - Required: after the load edge, `wdo`=`wbData`=0xDEADBEEF, `wdestReg`=5, `wwreg`=1.
- **ALU writeback**
  - Stimulus: `mm2reg`=0, `mr`=0x1234 (R-type).
  - Required: `wbData`=0x1234, memory unchanged, `memErr`=0.
- **Errors**
  - Misaligned case: store at 0x6.
    - Required: `memErr`=1 and the memory word at index 1 unchanged.
  - Out-of-range case: load at 0x100.
    - Required: `wdo`=0 and `memErr` remains 1 until `rst`.
- **Stall**
  - Stimulus: with `stall`=1, present a store of 0x55 to 0x4 and change every input.
  - Required: the W outputs hold their prior values and `mem[1]` is unchanged; after `stall` drops, the store commits.
- **Reset mid-clear**
  - Stimulus: assert `rst` at clear index 30, release it, then store a word before the clear completes.
  - Required: `busy` lasts a full 64 cycles after the release, the early store is dropped, and all words read 0.
